wfg_stim_wave: RTL and testbench

//  Parametrised multi-mode stimulus generator: phase accumulator (NCO) drives a shaper (saw/triangle/square/DC),

---
 rtl/wfg_stim_wave_pkg.sv | 32 +++
 rtl/wfg_stim_wave_shaper.sv | 38 +++
 rtl/wfg_stim_wave.sv | 207 ++++++++++++++++++++
 tb/tb_wfg_stim_wave.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/wfg_stim_wave_pkg.sv
// Shared types, constants and helpers for the wfg_stim_wave stimulus core.
// Saturation helper works on a wide signed value for any target width.
package wfg_stim_wave_pkg;

    typedef enum logic [1:0] {
        WAVE_SAW = 2'd0,
        WAVE_TRI = 2'd1,
        WAVE_SQR = 2'd2,
        WAVE_DC  = 2'd3
    } mode_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam int          SAT_W     = 64;

    function automatic logic signed [SAT_W-1:0] sat_signed(
        input logic signed [SAT_W-1:0] x,
        input int unsigned             w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

endpackage

// File: rtl/wfg_stim_wave_shaper.sv
// Combinational phase + mode to signed shape (saw, triangle, square, DC).
// Unsigned shapes become signed by inverting the MSB.
module wfg_stim_wave_shaper
    import wfg_stim_wave_pkg::*;
#(
    parameter int DATA_W  = 18,
    parameter int PHASE_W = 24
) (
    input  logic [PHASE_W-1:0]       i_phase,
    input  mode_t                    i_mode,
    output logic signed [DATA_W-1:0] o_shape
);

    logic [DATA_W-1:0]  w_saw;
    logic [DATA_W-1:0]  w_tri_raw;
    logic [DATA_W-1:0]  w_tri;
    logic [PHASE_W-1:0] w_unused_phase;

    assign w_unused_phase = i_phase;
    assign w_saw     = i_phase[PHASE_W-1 -: DATA_W];
    assign w_tri_raw = i_phase[PHASE_W-2 -: DATA_W];
    assign w_tri     = i_phase[PHASE_W-1] ? ~w_tri_raw : w_tri_raw;

    // Select the shape for the captured mode
    always_comb begin
        o_shape = '0;
        unique case (i_mode)
            WAVE_SAW: o_shape = {~w_saw[DATA_W-1], w_saw[DATA_W-2:0]};
            WAVE_TRI: o_shape = {~w_tri[DATA_W-1], w_tri[DATA_W-2:0]};
            WAVE_SQR: o_shape = i_phase[PHASE_W-1] ?
                                {1'b1, {(DATA_W-1){1'b0}}} :
                                {1'b0, {(DATA_W-1){1'b1}}};
            WAVE_DC:  o_shape = '0;
            default:  o_shape = '0;
        endcase
    end

endmodule

// File: rtl/wfg_stim_wave.sv
// NCO + shaper + gain/offset/saturate stimulus source on an AXIS master.
// Optional dither via `define WFG_STIM_WAVE_DITHER_EN.
module wfg_stim_wave
    import wfg_stim_wave_pkg::*;
#(
    parameter int DATA_W  = 18,
    parameter int PHASE_W = 24,
    parameter int GAIN_W  = 16
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               ctrl_en_i,
    input  logic               ctrl_dither_i,
    input  logic [1:0]         mode_i,
    input  logic [PHASE_W-1:0] inc_i,
    input  logic [GAIN_W-1:0]  gain_i,
    input  logic [DATA_W-1:0]  offset_i,
    input  logic               wfg_stim_tready_i,
    output logic               wfg_stim_tvalid_o,
    output logic [DATA_W-1:0]  wfg_stim_tdata_o,
    output logic               wfg_stim_tuser_o
);

    localparam int PROD_W = DATA_W + GAIN_W + 1;
    localparam int SUM_W  = PROD_W + 1;

    logic               w_adv;
    logic               w_issue;
    logic               w_carry;
    logic [PHASE_W-1:0] w_acc_nxt;

    logic [PHASE_W-1:0] r_acc;
    logic               r_first;
    logic               r_wrap;

    logic               r_s1_valid;
    logic [PHASE_W-1:0] r_s1_phase;
    mode_t              r_s1_mode;
    logic [GAIN_W-1:0]  r_s1_gain;
    logic [DATA_W-1:0]  r_s1_off;
    logic               r_s1_tuser;

    logic signed [DATA_W-1:0] w_shape;
    logic                     r_s2_valid;
    logic signed [DATA_W-1:0] r_s2_shape;
    logic [GAIN_W-1:0]        r_s2_gain;
    logic [DATA_W-1:0]        r_s2_off;
    logic                     r_s2_tuser;

    logic signed [PROD_W-1:0] w_prod;
    logic                     r_s3_valid;
    logic signed [PROD_W-1:0] r_s3_scaled;
    logic [DATA_W-1:0]        r_s3_off;
    logic                     r_s3_tuser;

    logic signed [SUM_W-1:0] w_dith;
    logic signed [SUM_W-1:0] w_sum;
    logic signed [SAT_W-1:0] w_sat;

    logic              r_tvalid;
    logic [DATA_W-1:0] r_tdata;
    logic              r_tuser;

    assign w_adv   = !r_tvalid | wfg_stim_tready_i;
    assign w_issue = ctrl_en_i & w_adv;
    assign {w_carry, w_acc_nxt} = {1'b0, r_acc} + {1'b0, inc_i};

`ifdef WFG_STIM_WAVE_DITHER_EN
    logic [15:0] r_lfsr;
    logic [1:0]  r_s1_dith;
    logic [1:0]  r_s2_dith;
    logic [1:0]  r_s3_dith;

    // Galois LFSR steps once per issued sample
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            r_lfsr <= LFSR_SEED;
        else if (w_issue)
            r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0);
    end

    // Dither enable and sign ride along with their sample
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_s1_dith <= '0;
            r_s2_dith <= '0;
            r_s3_dith <= '0;
        end else if (w_adv) begin
            if (ctrl_en_i)
                r_s1_dith <= {ctrl_dither_i, r_lfsr[0]};
            r_s2_dith <= r_s1_dith;
            r_s3_dith <= r_s2_dith;
        end
    end

    assign w_dith = !r_s3_dith[1] ? '0 :
                    r_s3_dith[0]  ? SUM_W'(1) : '1;
`else
    logic w_unused_dither;
    assign w_unused_dither = ctrl_dither_i;
    assign w_dith          = '0;
`endif

    // Phase accumulator; cleared and re-armed for tuser while disabled
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !ctrl_en_i) begin
            r_acc   <= '0;
            r_first <= 1'b1;
            r_wrap  <= 1'b0;
        end else if (w_adv) begin
            r_acc   <= w_acc_nxt;
            r_first <= 1'b0;
            r_wrap  <= w_carry;
        end
    end

    // S1: capture phase and config together
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_s1_valid <= 1'b0;
            r_s1_phase <= '0;
            r_s1_mode  <= WAVE_SAW;
            r_s1_gain  <= '0;
            r_s1_off   <= '0;
            r_s1_tuser <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= ctrl_en_i;
            if (ctrl_en_i) begin
                r_s1_phase <= r_acc;
                r_s1_mode  <= mode_t'(mode_i);
                r_s1_gain  <= gain_i;
                r_s1_off   <= offset_i;
                r_s1_tuser <= r_first | r_wrap;
            end
        end
    end

    wfg_stim_wave_shaper #(
        .DATA_W  (DATA_W),
        .PHASE_W (PHASE_W)
    ) u_shaper (
        .i_phase (r_s1_phase),
        .i_mode  (r_s1_mode),
        .o_shape (w_shape)
    );

    // S2: register the shaped sample
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_s2_valid <= 1'b0;
            r_s2_shape <= '0;
            r_s2_gain  <= '0;
            r_s2_off   <= '0;
            r_s2_tuser <= 1'b0;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            r_s2_shape <= w_shape;
            r_s2_gain  <= r_s1_gain;
            r_s2_off   <= r_s1_off;
            r_s2_tuser <= r_s1_tuser;
        end
    end

    assign w_prod = r_s2_shape * $signed({1'b0, r_s2_gain});

    // S3: gain multiply, floor-scaled back to unity
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_s3_valid  <= 1'b0;
            r_s3_scaled <= '0;
            r_s3_off    <= '0;
            r_s3_tuser  <= 1'b0;
        end else if (w_adv) begin
            r_s3_valid  <= r_s2_valid;
            r_s3_scaled <= w_prod >>> (GAIN_W - 2);
            r_s3_off    <= r_s2_off;
            r_s3_tuser  <= r_s2_tuser;
        end
    end

    assign w_sum =
        {{(SUM_W-PROD_W){r_s3_scaled[PROD_W-1]}}, r_s3_scaled} +
        {{(SUM_W-DATA_W){r_s3_off[DATA_W-1]}}, r_s3_off} +
        w_dith;
    assign w_sat = sat_signed({{(SAT_W-SUM_W){w_sum[SUM_W-1]}}, w_sum},
                              DATA_W);

    // OUT: offset, saturate and hold until the sink accepts
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tuser  <= 1'b0;
        end else if (w_adv) begin
            r_tvalid <= r_s3_valid;
            if (r_s3_valid) begin
                r_tdata <= DATA_W'(w_sat);
                r_tuser <= r_s3_tuser;
            end
        end
    end

    assign wfg_stim_tvalid_o = r_tvalid;
    assign wfg_stim_tdata_o  = r_tdata;
    assign wfg_stim_tuser_o  = r_tuser;

endmodule

// File: tb/tb_wfg_stim_wave.sv
// Directed bench for wfg_stim_wave with hand-computed expectations.
// Inputs change and outputs are checked on the falling clock edge.
module tb_wfg_stim_wave;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        dith;
    logic [1:0]  mode;
    logic [23:0] inc;
    logic [15:0] gain;
    logic [17:0] off;
    logic        tready;
    logic        tvalid;
    logic [17:0] tdata;
    logic        tuser;

    int n_chk = 0;
    int n_err = 0;

    int tri_tab [8] = '{-131072, -65536, 0, 65536,
                        131071, 65535, -1, -65537};

    always #5 clk = ~clk;

    wfg_stim_wave #(
        .DATA_W  (18),
        .PHASE_W (24),
        .GAIN_W  (16)
    ) dut (
        .wb_clk_i          (clk),
        .wb_rst_i          (rst),
        .ctrl_en_i         (en),
        .ctrl_dither_i     (dith),
        .mode_i            (mode),
        .inc_i             (inc),
        .gain_i            (gain),
        .offset_i          (off),
        .wfg_stim_tready_i (tready),
        .wfg_stim_tvalid_o (tvalid),
        .wfg_stim_tdata_o  (tdata),
        .wfg_stim_tuser_o  (tuser)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sdata();
        return int'($signed(tdata));
    endfunction

    function automatic int saw_exp(input int i);
        return -131072 + (i % 16) * 16384;
    endfunction

    task automatic start_wave(input logic [1:0]  m,
                              input logic [23:0] ic,
                              input logic [15:0] g,
                              input logic [17:0] o);
        en = 1'b0;
        repeat (5) @(negedge clk);
        chk("drained_tvalid", int'(tvalid), 0);
        mode = m;
        inc  = ic;
        gain = g;
        off  = o;
        en   = 1'b1;
        repeat (3) @(negedge clk);
        chk("latency_tvalid", int'(tvalid), 0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        dith   = 1'b0;
        mode   = 2'd0;
        inc    = '0;
        gain   = 16'h4000;
        off    = '0;
        tready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_tvalid", int'(tvalid), 0);
        chk("rst_tdata", sdata(), 0);
        chk("rst_tuser", int'(tuser), 0);
        rst = 1'b0;

        // Saw, unity gain: period of 16 samples
        start_wave(2'd0, 24'h100000, 16'h4000, 18'd0);
        for (int i = 0; i < 18; i++) begin
            chk("saw_tvalid", int'(tvalid), 1);
            chk("saw_data", sdata(), saw_exp(i));
            chk("saw_tuser", int'(tuser), (i % 16 == 0) ? 1 : 0);
            @(negedge clk);
        end

        // Backpressure for 5 cycles holds sample 18
        chk("bp_first", sdata(), saw_exp(18));
        tready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_valid", int'(tvalid), 1);
            chk("bp_hold_data", sdata(), saw_exp(18));
            chk("bp_hold_tuser", int'(tuser), 0);
        end
        tready = 1'b1;
        for (int i = 19; i < 23; i++) begin
            @(negedge clk);
            chk("bp_resume", sdata(), saw_exp(i));
            chk("bp_resume_tuser", int'(tuser), (i % 16 == 0) ? 1 : 0);
        end

        // Square with gain ~2.0 saturates both ways
        start_wave(2'd2, 24'h100000, 16'h7FFF, 18'd0);
        for (int i = 0; i < 16; i++) begin
            chk("sqr_data", sdata(), (i < 8) ? 131071 : -131072);
            chk("sqr_tuser", int'(tuser), (i == 0) ? 1 : 0);
            @(negedge clk);
        end

        // DC carries only the offset
        start_wave(2'd3, 24'h100000, 16'h1234, 18'h01000);
        for (int i = 0; i < 4; i++) begin
            chk("dc_data", sdata(), 4096);
            @(negedge clk);
        end

        // Triangle, 8 samples per period, peak at sample 4
        start_wave(2'd1, 24'h200000, 16'h4000, 18'd0);
        for (int i = 0; i < 8; i++) begin
            chk("tri_data", sdata(), tri_tab[i]);
            chk("tri_tuser", int'(tuser), (i == 0) ? 1 : 0);
            @(negedge clk);
        end
        chk("tri_wrap_data", sdata(), tri_tab[0]);
        chk("tri_wrap_tuser", int'(tuser), 1);

        // Disable while stalled: held sample stays, then 3 drain
        tready = 1'b0;
        en     = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("dis_hold_valid", int'(tvalid), 1);
            chk("dis_hold_data", sdata(), tri_tab[0]);
        end
        tready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk("drain_valid", int'(tvalid), 1);
            chk("drain_data", sdata(), tri_tab[i]);
        end
        @(negedge clk);
        chk("drain_empty", int'(tvalid), 0);

        // Re-enable restarts at phase 0 with tuser
        start_wave(2'd1, 24'h200000, 16'h4000, 18'd0);
        chk("reen_data", sdata(), tri_tab[0]);
        chk("reen_tuser", int'(tuser), 1);
        @(negedge clk);
        chk("reen_next", sdata(), tri_tab[1]);

        // Reset mid-stream
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_tvalid", int'(tvalid), 0);
        chk("mrst_tdata", sdata(), 0);
        chk("mrst_tuser", int'(tuser), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("mrst_latency", int'(tvalid), 0);
        @(negedge clk);
        chk("mrst_first", sdata(), tri_tab[0]);
        chk("mrst_tuser1", int'(tuser), 1);

        // Zero increment: constant phase, tuser only once
        start_wave(2'd0, 24'h000000, 16'h4000, 18'd0);
        for (int i = 0; i < 4; i++) begin
            chk("inc0_valid", int'(tvalid), 1);
            chk("inc0_data", sdata(), -131072);
            chk("inc0_tuser", int'(tuser), (i == 0) ? 1 : 0);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
